// File: rtl/bidir_pad_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bidir_pad_sequencer_pkg
// Description : Shared state encodings, parameter defaults and pad constants
//               for the bidirectional single-wire pad sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package bidir_pad_sequencer_pkg;

    // Parameter defaults
    localparam int c_BIT_DIV_DEFAULT      = 4;
    localparam int c_TURN_CYC_DEFAULT     = 2;
    localparam int c_TIMEOUT_BITS_DEFAULT = 4;

    // FSM encodings
    localparam int         c_STATE_W       = 3;
    localparam logic [2:0] c_ST_IDLE       = 3'd0;
    localparam logic [2:0] c_ST_TX         = 3'd1;
    localparam logic [2:0] c_ST_TURN       = 3'd2;
    localparam logic [2:0] c_ST_WAIT_START = 3'd3;
    localparam logic [2:0] c_ST_RX         = 3'd4;
    localparam logic [2:0] c_ST_DONE       = 3'd5;

    // Idle (released / pulled-up) pad level
    localparam logic c_PAD_IDLE = 1'b1;

    // Frame bit indices: TX index 0 is the start bit, 1..8 are D7..D0;
    // RX index 0..7 are D7..D0
    localparam logic [3:0] c_TX_LAST_BIT = 4'd8;
    localparam logic [3:0] c_RX_LAST_BIT = 4'd7;

endpackage
`default_nettype wire

// File: rtl/bidir_pad_sequencer_pad_sync2.sv
`default_nettype none
// ============================================================================
// Module      : pad_sync2
// Description : Two-flop synchronizer for the asynchronous pad readback.
//               Resets to the released pad level so that no start bit is
//               seen while coming out of reset.
// Revision    : 1.0 - initial release
// ============================================================================
module pad_sync2
    import bidir_pad_sequencer_pkg::*;
(
    input  logic CLK,
    input  logic RSTN,
    input  logic i_async,
    output logic o_sync
);

    logic [1:0] r_sync;

    // Shift the asynchronous pad level through two flops
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_sync <= {2{c_PAD_IDLE}};
        end else begin
            r_sync <= {r_sync[0], i_async};
        end
    end

    assign o_sync = r_sync[1];

endmodule
`default_nettype wire

// File: rtl/bidir_pad_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : bidir_pad_sequencer
// Description : Sends one byte (start bit + D7..D0) on a bidirectional pad,
//               releases the bus, and optionally receives a one-byte
//               response with start-bit qualification and timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module bidir_pad_sequencer
    import bidir_pad_sequencer_pkg::*;
#(
    parameter int BIT_DIV      = c_BIT_DIV_DEFAULT,
    parameter int TURN_CYC     = c_TURN_CYC_DEFAULT,
    parameter int TIMEOUT_BITS = c_TIMEOUT_BITS_DEFAULT
) (
    input  logic       CLK,
    input  logic       RSTN,
    input  logic       TX_VALID,
    input  logic [7:0] TX_DATA,
    input  logic       RSP_EN,
    output logic       TX_READY,
    output logic [7:0] RX_DATA,
    output logic       RX_VALID,
    output logic       RX_ERR,
    output logic       PAD_I,
    output logic       PAD_T,
    input  logic       PAD_O
);

    // One shared cycle counter serves bit timing, turnaround and half-bit
    localparam int c_CNT_MAX = (BIT_DIV > TURN_CYC) ? BIT_DIV : TURN_CYC;
    localparam int c_CNT_W   = (c_CNT_MAX > 1) ? $clog2(c_CNT_MAX) : 1;
    localparam int c_TO_MAX  = TIMEOUT_BITS * BIT_DIV;
    localparam int c_TO_W    = (c_TO_MAX > 1) ? $clog2(c_TO_MAX) : 1;

    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_BIT_LAST = c_CNT_W'(BIT_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_HALF_LAST = c_CNT_W'(BIT_DIV / 2 - 1);
    localparam logic [c_CNT_W-1:0] c_TURN_LAST = c_CNT_W'(TURN_CYC - 1);
    localparam logic [c_TO_W-1:0]  c_TO_ONE   = c_TO_W'(1);
    localparam logic [c_TO_W-1:0]  c_TO_LAST  = c_TO_W'(c_TO_MAX - 1);

    logic [c_STATE_W-1:0] r_state;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_TO_W-1:0]    r_to;
    logic [3:0]           r_bit_idx;
    logic [7:0]           r_tx_sh;
    logic [6:0]           r_rx_sh;
    logic                 r_rsp_en;
    logic                 r_hunt;
    logic                 r_pad_i;
    logic                 r_pad_t;
    logic [7:0]           r_rx_data;
    logic                 r_rx_valid;
    logic                 r_rx_err;
    logic                 w_pad_sync;

    pad_sync2 u_pad_sync2 (
        .CLK     (CLK),
        .RSTN    (RSTN),
        .i_async (PAD_O),
        .o_sync  (w_pad_sync)
    );

    // Sequencer FSM: transmit, turnaround, start-bit hunt, receive
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_state    <= c_ST_IDLE;
            r_cnt      <= '0;
            r_to       <= '0;
            r_bit_idx  <= '0;
            r_tx_sh    <= '0;
            r_rx_sh    <= '0;
            r_rsp_en   <= 1'b0;
            r_hunt     <= 1'b0;
            r_pad_i    <= c_PAD_IDLE;
            r_pad_t    <= 1'b1;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_rx_err   <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            r_rx_err   <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (TX_VALID) begin
                        r_state   <= c_ST_TX;
                        r_tx_sh   <= TX_DATA;
                        r_rsp_en  <= RSP_EN;
                        r_pad_t   <= 1'b0;
                        r_pad_i   <= 1'b0;
                        r_cnt     <= '0;
                        r_bit_idx <= '0;
                    end
                end
                c_ST_TX: begin
                    if (r_cnt == c_BIT_LAST) begin
                        r_cnt <= '0;
                        if (r_bit_idx == c_TX_LAST_BIT) begin
                            r_state <= c_ST_TURN;
                            r_pad_t <= 1'b1;
                            r_pad_i <= c_PAD_IDLE;
                        end else begin
                            r_bit_idx <= r_bit_idx + 4'd1;
                            r_pad_i   <= r_tx_sh[7];
                            r_tx_sh   <= {r_tx_sh[6:0], 1'b0};
                        end
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                c_ST_TURN: begin
                    if (r_cnt == c_TURN_LAST) begin
                        r_cnt <= '0;
                        if (r_rsp_en) begin
                            r_state <= c_ST_WAIT_START;
                            r_to    <= '0;
                            r_hunt  <= 1'b0;
                        end else begin
                            r_state <= c_ST_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                c_ST_WAIT_START: begin
                    // A confirmed start bit wins over a coincident timeout
                    if (r_hunt && (r_cnt == c_HALF_LAST) && !w_pad_sync) begin
                        r_state   <= c_ST_RX;
                        r_cnt     <= '0;
                        r_to      <= '0;
                        r_hunt    <= 1'b0;
                        r_bit_idx <= '0;
                    end else if (r_to == c_TO_LAST) begin
                        r_state  <= c_ST_IDLE;
                        r_rx_err <= 1'b1;
                        r_cnt    <= '0;
                        r_to     <= '0;
                        r_hunt   <= 1'b0;
                    end else begin
                        // Timeout keeps running through false starts
                        r_to <= r_to + c_TO_ONE;
                        if (r_hunt) begin
                            if (r_cnt == c_HALF_LAST) begin
                                r_hunt <= 1'b0;
                                r_cnt  <= '0;
                            end else begin
                                r_cnt <= r_cnt + c_CNT_ONE;
                            end
                        end else if (!w_pad_sync) begin
                            r_hunt <= 1'b1;
                            r_cnt  <= '0;
                        end
                    end
                end
                c_ST_RX: begin
                    if (r_cnt == c_BIT_LAST) begin
                        r_cnt   <= '0;
                        r_rx_sh <= {r_rx_sh[5:0], w_pad_sync};
                        if (r_bit_idx == c_RX_LAST_BIT) begin
                            r_state    <= c_ST_DONE;
                            r_rx_data  <= {r_rx_sh, w_pad_sync};
                            r_rx_valid <= 1'b1;
                        end else begin
                            r_bit_idx <= r_bit_idx + 4'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                c_ST_DONE: begin
                    r_state <= c_ST_IDLE;
                    r_cnt   <= '0;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_cnt   <= '0;
                    r_pad_t <= 1'b1;
                    r_pad_i <= c_PAD_IDLE;
                end
            endcase
        end
    end

    assign TX_READY = (r_state == c_ST_IDLE);
    assign RX_DATA  = r_rx_data;
    assign RX_VALID = r_rx_valid;
    assign RX_ERR   = r_rx_err;
    assign PAD_I    = r_pad_i;
    assign PAD_T    = r_pad_t;

endmodule
`default_nettype wire

// File: tb/tb_bidir_pad_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_bidir_pad_sequencer
// Description : Self-checking bench for bidir_pad_sequencer with a pulled-up
//               pad model and a byte-level response scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bidir_pad_sequencer;

    localparam int c_TIMEOUT_CYC = 16;

    logic       CLK;
    logic       RSTN;
    logic       TX_VALID;
    logic [7:0] TX_DATA;
    logic       RSP_EN;
    logic       TX_READY;
    logic [7:0] RX_DATA;
    logic       RX_VALID;
    logic       RX_ERR;
    logic       PAD_I;
    logic       PAD_T;
    logic       PAD_O;

    // Responder side of the pad
    logic       resp_drive;
    logic       resp_val;

    int         n_pass;
    int         n_checks;
    logic [7:0] exp_rx_data;
    logic [7:0] rx_q[$];

    bidir_pad_sequencer #(
        .BIT_DIV      (4),
        .TURN_CYC     (2),
        .TIMEOUT_BITS (4)
    ) dut (
        .CLK      (CLK),
        .RSTN     (RSTN),
        .TX_VALID (TX_VALID),
        .TX_DATA  (TX_DATA),
        .RSP_EN   (RSP_EN),
        .TX_READY (TX_READY),
        .RX_DATA  (RX_DATA),
        .RX_VALID (RX_VALID),
        .RX_ERR   (RX_ERR),
        .PAD_I    (PAD_I),
        .PAD_T    (PAD_T),
        .PAD_O    (PAD_O)
    );

    // Pad with pull-up: DUT drives when PAD_T=0, else responder or pull-up
    assign PAD_O = !PAD_T ? PAD_I : (resp_drive ? resp_val : 1'b1);

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Offer a byte at a negedge; accepted on the following posedge
    task automatic start_tx(input logic [7:0] d, input logic rsp);
        @(negedge CLK);
        TX_VALID = 1'b1;
        TX_DATA  = d;
        RSP_EN   = rsp;
        @(posedge CLK);
        #1 TX_VALID = 1'b0;
    endtask

    // Checks the 36-cycle frame after an accept, then the release cycle
    task automatic check_tx_frame(input logic [7:0] d, input bit poke);
        logic bit_q[$];
        logic b;
        bit_q.push_back(1'b0);
        for (int i = 7; i >= 0; i--) bit_q.push_back(d[i]);
        for (int k = 0; k < 9; k++) begin
            b = bit_q.pop_front();
            for (int c = 0; c < 4; c++) begin
                @(negedge CLK);
                n_checks++;
                if ({PAD_T, PAD_I} !== {1'b0, b}) begin
                    $display("FAIL tx_bit%0d_cyc%0d: PAD_T,PAD_I got %b%b expected 0%b",
                             k, c, PAD_T, PAD_I, b);
                end else begin
                    n_pass++;
                end
                if (k == 4 && c == 0) begin
                    n_checks++;
                    if (TX_READY !== 1'b0) $display("FAIL tx_ready_in_tx: got %b expected 0", TX_READY);
                    else n_pass++;
                end
                if (poke && k == 0 && c == 1) begin
                    TX_VALID = 1'b1;
                    TX_DATA  = 8'hFF;
                end
                if (poke && k == 2 && c == 0) TX_VALID = 1'b0;
            end
        end
        @(negedge CLK);
        n_checks++;
        if ({PAD_T, PAD_I, TX_READY} !== 3'b110) begin
            $display("FAIL tx_release: PAD_T,PAD_I,TX_READY got %b%b%b expected 110",
                     PAD_T, PAD_I, TX_READY);
        end else begin
            n_pass++;
        end
    endtask

    task automatic test_reset;
        RSTN = 1'b0; TX_VALID = 1'b0; TX_DATA = 8'h00; RSP_EN = 1'b0;
        resp_drive = 1'b0; resp_val = 1'b1;
        repeat (3) @(negedge CLK);
        n_checks++;
        if ({PAD_T, PAD_I, TX_READY, RX_VALID, RX_ERR} !== 5'b11100) begin
            $display("FAIL reset_outputs: T,I,RDY,VLD,ERR got %b%b%b%b%b expected 11100",
                     PAD_T, PAD_I, TX_READY, RX_VALID, RX_ERR);
        end else begin
            n_pass++;
        end
        n_checks++;
        if (RX_DATA !== 8'h00) $display("FAIL reset_rx_data: got %h expected 00", RX_DATA);
        else n_pass++;
        RSTN = 1'b1;
        exp_rx_data = 8'h00;
    endtask

    task automatic test_tx_no_rsp;
        int flags;
        start_tx(8'hA5, 1'b0);
        check_tx_frame(8'hA5, 1'b1);
        @(negedge CLK);
        n_checks++;
        if (TX_READY !== 1'b0) $display("FAIL turn_ready_1: got %b expected 0", TX_READY);
        else n_pass++;
        @(negedge CLK);
        n_checks++;
        if (TX_READY !== 1'b1) $display("FAIL turn_ready_2: got %b expected 1", TX_READY);
        else n_pass++;
        flags = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge CLK);
            if (RX_VALID || RX_ERR || !PAD_T || !TX_READY) flags++;
        end
        n_checks++;
        if (flags != 0) $display("FAIL idle_after_tx: got %0d bad cycles expected 0", flags);
        else n_pass++;
    endtask

    task automatic test_response;
        bit         got;
        int         t_low;
        logic [7:0] exp;
        logic [8:0] frame;
        start_tx(8'h01, 1'b1);
        check_tx_frame(8'h01, 1'b0);
        got   = 1'b0;
        t_low = 0;
        fork
            begin
                frame = {1'b0, 8'h3C};
                rx_q.push_back(8'h3C);
                repeat (4) @(negedge CLK);
                for (int i = 8; i >= 0; i--) begin
                    resp_drive = 1'b1;
                    resp_val   = frame[i];
                    repeat (4) @(negedge CLK);
                end
                resp_drive = 1'b0;
                resp_val   = 1'b1;
            end
            begin
                for (int c = 0; c < 80 && !got; c++) begin
                    @(negedge CLK);
                    if (!PAD_T) t_low++;
                    if (RX_VALID) begin
                        got = 1'b1;
                        n_checks++;
                        if (rx_q.size() == 0) begin
                            $display("FAIL rx_unexpected: got %h expected no output", RX_DATA);
                        end else begin
                            exp = rx_q.pop_front();
                            exp_rx_data = exp;
                            if (RX_DATA !== exp) $display("FAIL rx_data: got %h expected %h", RX_DATA, exp);
                            else n_pass++;
                        end
                    end
                end
                n_checks++;
                if (!got) $display("FAIL rx_valid_seen: got 0 expected 1 within 80 cycles");
                else n_pass++;
                @(negedge CLK);
                n_checks++;
                if ({RX_VALID, TX_READY} !== 2'b01) begin
                    $display("FAIL rx_valid_pulse: VLD,RDY got %b%b expected 01", RX_VALID, TX_READY);
                end else begin
                    n_pass++;
                end
            end
        join
        n_checks++;
        if (t_low != 0) $display("FAIL no_drive_in_rx: got %0d PAD_T=0 cycles expected 0", t_low);
        else n_pass++;
    endtask

    // Optional one-cycle glitch 4 cycles after release; RX_ERR must still
    // arrive 16 cycles after WAIT_START entry (2 edges after this point)
    task automatic test_timeout(input bit glitch);
        int  lat;
        int  vld;
        start_tx(8'h5A, 1'b1);
        check_tx_frame(8'h5A, 1'b0);
        lat = -1;
        vld = 0;
        for (int c = 1; c <= 40 && lat < 0; c++) begin
            @(negedge CLK);
            if (RX_VALID) vld++;
            if (RX_ERR) lat = c - 2;
            if (glitch && c == 4) begin
                resp_drive = 1'b1;
                resp_val   = 1'b0;
            end
            if (glitch && c == 5) begin
                resp_drive = 1'b0;
                resp_val   = 1'b1;
            end
        end
        n_checks++;
        if (lat != c_TIMEOUT_CYC) begin
            $display("FAIL rx_err_latency(glitch=%0d): got %0d expected %0d", glitch, lat, c_TIMEOUT_CYC);
        end else begin
            n_pass++;
        end
        n_checks++;
        if ({TX_READY, RX_DATA} !== {1'b1, exp_rx_data}) begin
            $display("FAIL timeout_idle(glitch=%0d): RDY,RX_DATA got %b %h expected 1 %h",
                     glitch, TX_READY, RX_DATA, exp_rx_data);
        end else begin
            n_pass++;
        end
        @(negedge CLK);
        if (RX_VALID) vld++;
        n_checks++;
        if (RX_ERR !== 1'b0) $display("FAIL rx_err_pulse(glitch=%0d): got %b expected 0", glitch, RX_ERR);
        else n_pass++;
        n_checks++;
        if (vld != 0) $display("FAIL no_rx_on_timeout(glitch=%0d): got %0d expected 0", glitch, vld);
        else n_pass++;
    endtask

    task automatic test_reset_mid_tx;
        start_tx(8'h00, 1'b0);
        repeat (10) @(negedge CLK);
        n_checks++;
        if (PAD_T !== 1'b0) $display("FAIL mid_tx_driving: got %b expected 0", PAD_T);
        else n_pass++;
        #2 RSTN = 1'b0;
        #1;
        n_checks++;
        if ({PAD_T, PAD_I, TX_READY} !== 3'b111) begin
            $display("FAIL async_reset_release: T,I,RDY got %b%b%b expected 111", PAD_T, PAD_I, TX_READY);
        end else begin
            n_pass++;
        end
        @(negedge CLK);
        RSTN     = 1'b1;
        TX_VALID = 1'b1;
        TX_DATA  = 8'hC3;
        RSP_EN   = 1'b0;
        @(posedge CLK);
        #1 TX_VALID = 1'b0;
        check_tx_frame(8'hC3, 1'b0);
        repeat (2) @(negedge CLK);
        n_checks++;
        if (TX_READY !== 1'b1) $display("FAIL post_reset_idle: got %b expected 1", TX_READY);
        else n_pass++;
    endtask

    initial begin
        n_pass   = 0;
        n_checks = 0;
        test_reset();
        test_tx_no_rsp();
        test_response();
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_reset_mid_tx();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bidir_pad_sequencer.md
BIDIR_PAD_SEQUENCER -- requirements
Module: bidir_pad_sequencer

Interface
REQ-001 SHALL have parameter BIT_DIV, default 4: clocks per bit time, even, >=4.
REQ-002 SHALL have parameter TURN_CYC, default 2: released-bus clocks between TX end and RX listen.
REQ-003 SHALL have parameter TIMEOUT_BITS, default 4: bit times to wait for a response start bit.
REQ-004 SHALL have port CLK  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port RSTN  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port TX_VALID  input  1  host offers a byte.
REQ-007 SHALL have port TX_DATA  input  8  byte to send, MSB first.
REQ-008 SHALL have port RSP_EN  input  1  response expected; sampled with TX accept.
REQ-009 SHALL have port TX_READY  output  1  high only in IDLE.
REQ-010 SHALL have port RX_DATA  output  8  last received byte; held until next RX completes.
REQ-011 SHALL have port RX_VALID  output  1  one-cycle pulse, RX_DATA valid.
REQ-012 SHALL have port RX_ERR  output  1  one-cycle pulse on response timeout.
REQ-013 SHALL have port PAD_I  output  1  drive value to pad buffer I.
REQ-014 SHALL have port PAD_T  output  1  pad tristate control; 1 = released, 0 = driving.
REQ-015 SHALL have port PAD_O  input  1  pad readback from buffer O; asynchronous to CLK.

Function
REQ-016 SHALL implement states IDLE, TX, TURN, WAIT_START, RX, DONE.
REQ-017 Accept on TX_VALID & TX_READY; latch TX_DATA and RSP_EN; IDLE->TX; TX_VALID outside IDLE SHALL be ignored, no queuing.
REQ-018 TX: PAD_T=0 from cycle after accept; drive start bit 0 then D7..D0, each exactly BIT_DIV clocks (9*BIT_DIV total); PAD_I, PAD_T registered.
REQ-019 TX end: PAD_T=1, PAD_I=1 same edge; TURN lasts TURN_CYC clocks; then WAIT_START if RSP_EN latched, else IDLE.
REQ-020 PAD_O SHALL pass through a 2-flop synchronizer; all RX decisions use the synchronized value (2-cycle latency).
REQ-021 WAIT_START: synchronized low starts half-bit counter (BIT_DIV/2); if still low at half-bit -> RX, else false start, return to WAIT_START; timeout counter not reset by false start.
REQ-022 WAIT_START exceeding TIMEOUT_BITS*BIT_DIV clocks: RX_ERR pulse 1 cycle, -> IDLE, RX_DATA unchanged.
REQ-023 RX: sample 8 bits every BIT_DIV clocks from start-bit midpoint, shift MSB first; after bit 0 -> DONE.
REQ-024 DONE: RX_DATA updated, RX_VALID=1 for exactly one cycle, -> IDLE next cycle.
REQ-025 PAD_T SHALL be 1 in every state except TX; no cycle with PAD_T=0 outside TX.
REQ-026 Bit and timeout counters sized $clog2 of max count; no wrap inside a state; cleared on every state entry.

Reset
REQ-027 RSTN low SHALL asynchronously force IDLE, PAD_T=1, PAD_I=1, TX_READY=1, RX_VALID=0, RX_ERR=0, RX_DATA=8'h00, synchronizer flops=1, counters=0.
REQ-028 Reset mid-TX SHALL release pad immediately; latched byte discarded; first accept possible on first edge after RSTN rises.

Structure
REQ-029 Shared package SHALL hold state encodings and parameter defaults (BIT_DIV, TURN_CYC, TIMEOUT_BITS).
REQ-030 Synchronizer SHALL be sub-module pad_sync2 (reset value 1, async active-low RSTN); rest flat.

Verification (BIT_DIV=4, TURN_CYC=2, TIMEOUT_BITS=4; pad modelled with pull-up keeper)
REQ-031 Reset: RSTN low -> PAD_T=1, PAD_I=1, TX_READY=1, RX_VALID=0, RX_ERR=0.
REQ-032 TX 8'hA5, RSP_EN=0 -> PAD_T=0 36 cycles, PAD_I 0,1,0,1,0,0,1,0,1 each 4 cycles; TX_READY=1 2 cycles after release; TX_VALID during TX ignored.
REQ-033 TX 8'h01, RSP_EN=1, responder drives start + 8'h3C at 4 clk/bit -> RX_VALID one cycle, RX_DATA=8'h3C, no PAD_T=0 during RX.
REQ-034 RSP_EN=1, no response -> RX_ERR pulse 16 cycles after WAIT_START entry, back to IDLE.
REQ-035 One-cycle low glitch in WAIT_START -> no RX entry, RX_ERR still at 16 cycles.
REQ-036 RSTN low mid-TX -> PAD_T=1 before next CLK edge, IDLE after RSTN rises.
